// File: rtl/pc_unit.sv
// Program-counter unit: registered PC with stall and branch/jump/jr redirects,
// an exception vector with EPC/EXL, and a return-address stack for jal / jr $ra.
module pc_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      instruction,
  input  logic             branch_control,
  input  logic             alu_zero_control,
  input  logic             jump_control,
  input  logic             link_control,
  input  logic             jr_control,
  input  logic             ret_control,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exception,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             exl,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             addr_error
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             exl_q, exl_d;
  logic             aerr_q, aerr_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic             ras_we;

  logic [WIDTH-1:0] branch_tgt, jump_tgt, jr_sel, ras_top;
  logic             ras_hit, misaligned, take_exc, redirect_ok, do_pop, do_push;
  logic             unused_opcode;

  assign unused_opcode = ^instruction[31:26];

  assign pc_plus4   = pc_q + WIDTH'(4);
  assign branch_tgt = pc_plus4 + {{(WIDTH-18){instruction[15]}}, instruction[15:0], 2'b00};
  assign jump_tgt   = {pc_plus4[WIDTH-1:28], instruction[25:0], 2'b00};

  // Top of stack sits one below the write pointer.
  assign ras_top    = ras_q[ptr_q - PTR_W'(1)];
  assign ras_empty  = (cnt_q == '0);
  assign ras_full   = (cnt_q == FULL_CNT);
  assign ras_hit    = ret_control && !ras_empty;
  assign jr_sel     = ras_hit ? ras_top : jr_target;

  assign misaligned  = jr_control && (jr_sel[1:0] != 2'b00);
  assign take_exc    = exception || misaligned;
  assign redirect_ok = !take_exc && !eret && !stall;
  assign do_pop      = redirect_ok && jr_control && ras_hit;
  assign do_push     = redirect_ok && jump_control && link_control && !do_pop;

  // Next-PC and mode selection.
  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    exl_d  = exl_q;
    aerr_d = misaligned;
    if (take_exc) begin
      pc_d = WIDTH'(EXC_VECTOR);
      if (!exl_q) begin
        epc_d = pc_q;
        exl_d = 1'b1;
      end
    end else if (eret) begin
      pc_d  = epc_q;
      exl_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (jr_control) begin
      pc_d = jr_sel;
    end else if (jump_control) begin
      pc_d = jump_tgt;
    end else if (branch_control && alu_zero_control) begin
      pc_d = branch_tgt;
    end else begin
      pc_d = pc_plus4;
    end
  end

  // Stack pointer/count; a full push overwrites the oldest slot.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ras_we = 1'b0;
    if (do_pop) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else if (do_push) begin
      ras_we = 1'b1;
      ptr_d  = ptr_q + PTR_W'(1);
      cnt_d  = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= WIDTH'(RESET_VECTOR);
      epc_q  <= '0;
      exl_q  <= 1'b0;
      aerr_q <= 1'b0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      exl_q  <= exl_d;
      aerr_q <= aerr_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && ras_we) begin
      ras_q[ptr_q] <= pc_plus4;
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign exl        = exl_q;
  assign addr_error = aerr_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the MIPS core. It is the successor of the single-cycle PC: a registered PC with a stall hold, branch/jump/jump-register redirects and a correct jump target. It adds an exception vector with an EPC register and EXL mode bit, and a depth-parametrised return-address stack (RAS) for jal/jr $ra. It feeds the instruction-memory address and takes its controls from the main decoder and the ALU zero flag.

Parameters:
WIDTH, 32, PC/address width; legal range 29..32.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h0000_0180, PC value loaded on exception.
RAS_DEPTH, 4, number of return-address stack entries; power of 2, minimum 2.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  hold PC; suppresses RAS push/pop and non-exception redirects.
instruction  in  32  current instruction; [15:0] branch offset, [25:0] jump index.
branch_control  in  1  conditional branch decoded.
alu_zero_control  in  1  ALU zero flag; branch is taken when branch_control and this flag are both 1.
jump_control  in  1  j/jal decoded.
link_control  in  1  jal decoded; pushes pc_plus4 onto the RAS.
jr_control  in  1  jr decoded.
ret_control  in  1  jr is jr $ra; pop the RAS.
jr_target  in  WIDTH  register-file value for jr.
exception  in  1  synchronous exception request.
eret  in  1  return from exception.
pc  out  WIDTH  current PC, registered.
pc_plus4  out  WIDTH  pc+4, combinational.
epc  out  WIDTH  exception PC, registered.
exl  out  1  exception-level mode bit.
ras_empty  out  1  RAS holds no valid entries.
ras_full  out  1  RAS holds RAS_DEPTH valid entries.
addr_error  out  1  one-cycle pulse on a misaligned jr target.

Behaviour:
- Reset (synchronous, active-high): pc=RESET_VECTOR, epc=0, exl=0, RAS count=0, RAS pointer=0, addr_error=0. Reset overrides every other input.
- Arithmetic is modulo 2^WIDTH.
  - pc_plus4 = pc+4.
  - Branch target = pc_plus4 + (sign-extended instruction[15:0] << 2).
  - Jump target = {pc_plus4[WIDTH-1:28], instruction[25:0], 2'b00}.
- jr target selection:
  - If ret_control=1 and RAS is not empty: target is the RAS top.
  - Otherwise: target is jr_target. A ret_control with an empty RAS falls back to jr_target and pops nothing.
- Misaligned jr: if the selected jr target has [1:0]!=0, it is treated as an exception and addr_error pulses for 1 cycle.
- Next-PC priority, one decision per rising edge, highest first:
  1. reset.
  2. exception or misaligned jr -> pc=EXC_VECTOR. If exl=0: epc=pc and exl=1. If exl=1: epc is unchanged (no nesting). This applies even when stall=1.
  3. eret (no exception) -> pc=epc, exl=0. This applies even when stall=1.
  4. stall -> pc held; no RAS change.
  5. jr_control -> selected jr target.
  6. jump_control -> jump target.
  7. branch_control and alu_zero_control -> branch target.
  8. Otherwise pc=pc_plus4.
- Latency: redirects take effect on the edge after the controls are sampled; no bubble is inserted by this block.
- RAS push:
  - Occurs when link_control=1 and jump_control=1, no stall, and no exception/eret.
  - Pushes pc_plus4 at the pointer; pointer increments with wrap.
  - When full, the oldest entry is overwritten and count saturates at RAS_DEPTH.
- RAS pop:
  - Occurs when ret_control=1 and jr_control=1, no stall, no exception/eret, and the RAS is not empty.
  - Pointer decrements with wrap; count decrements.
- Push and pop in the same cycle is illegal per the decoder; the block gives pop priority and ignores the push.
- Exception, reset or eret in a cycle discards any push/pop in that cycle. RAS contents survive exceptions.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH). Both are derived from registered state.
- Reset asserted mid-operation clears the RAS and exl immediately on that edge; epc=0.
- Controls are don't-care while reset=1.

Test Plan:
1. Reset, then 4 idle cycles -> pc = 0, 4, 8, 12, 16; epc=0, exl=0, ras_empty=1.
2. pc=0x100, beq with offset 0xFFFF, zero=1 -> next pc=0x100. Same with zero=0 -> 0x104. Same with stall=1 -> pc stays 0x100.
3. pc=0x1000_0040, j with index 0x0000040 -> pc=0x1000_0100. Repeat with jal -> RAS top=0x1000_0044, ras_empty=0.
4. Five jals at 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH=4 -> ras_full=1. Then five jr $ra -> pc = 0x54, 0x44, 0x34, 0x24. The fifth pop is on an empty RAS, so pc=jr_target and ras_empty=1.
5. pc=0x200, exception -> pc=0x180, epc=0x200, exl=1. A second exception at 0x184 -> epc stays 0x200. eret -> pc=0x200, exl=0.
6. jr with jr_target=0x302 -> addr_error pulses 1 cycle, pc=0x180, epc=old pc. Exception asserted together with stall=1 and jump_control=1 -> vector still taken.
